// File: rtl/prm_edge_mask_scanner_pkg.sv
// Shared types, defaults and helpers for the PRM edge-mask scanner.
package prm_pkg;

  localparam int unsigned CODE_W_DEF = 15;
  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned WORD_W_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } scan_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/prm_edge_mask_scanner_if.sv
// Config, query and result bundle between host loader, edge enumerator and scanner.
interface prm_edge_mask_scanner_if #(
  parameter int unsigned CODE_W = prm_pkg::CODE_W_DEF,
  parameter int unsigned NUM_CH = prm_pkg::NUM_CH_DEF,
  parameter int unsigned WORD_W = prm_pkg::WORD_W_DEF
);
  import prm_pkg::*;

  localparam int unsigned BIT_W  = clog2(WORD_W);
  localparam int unsigned ADDR_W = CODE_W - BIT_W;
  localparam int unsigned CH_W   = clog2(NUM_CH);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ADDR_W-1:0] cfg_addr;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_last;
  logic              clr_req;
  logic              q_valid;
  logic              q_ready;
  logic [CODE_W-1:0] q_code;
  logic [NUM_CH-1:0] q_ch_en;
  logic              r_valid;
  logic              r_ready;
  logic [NUM_CH-1:0] r_mask;
  logic              r_any;
  logic [NUM_CH-1:0] tbl_valid;
  logic              busy;

  modport master (
    output cfg_valid, cfg_ch, cfg_addr, cfg_data, cfg_last, clr_req,
    output q_valid, q_code, q_ch_en, r_ready,
    input  cfg_ready, q_ready, r_valid, r_mask, r_any, tbl_valid, busy
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_addr, cfg_data, cfg_last, clr_req,
    input  q_valid, q_code, q_ch_en, r_ready,
    output cfg_ready, q_ready, r_valid, r_mask, r_any, tbl_valid, busy
  );

endinterface

// File: rtl/prm_edge_mask_scanner_tbl_ram.sv
// Single-port truth-table word RAM: write wins, synchronous read, contents not reset.
module prm_tbl_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Read data holds when re_i is low so a stalled pipeline keeps its word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prm_edge_mask_scanner.sv
// Runtime-loadable obstacle truth tables answering edge-code queries with a per-channel blocked mask.
module prm_edge_mask_scanner
  import prm_pkg::*;
#(
  parameter int unsigned CODE_W = CODE_W_DEF,
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  prm_edge_mask_scanner_if.slave  bus
);

  localparam int unsigned BIT_W  = clog2(WORD_W);
  localparam int unsigned ADDR_W = CODE_W - BIT_W;
  localparam int unsigned CH_W   = clog2(NUM_CH);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rdy_en_q;
  logic [NUM_CH-1:0] tbl_valid_q, tbl_valid_d;
  logic              s1_valid_q, s1_valid_d;
  logic [BIT_W-1:0]  s1_bit_q, s1_bit_d;
  logic [NUM_CH-1:0] s1_en_q, s1_en_d;
  logic [NUM_CH-1:0] s1_tv_q, s1_tv_d;
  logic              r_valid_q, r_valid_d;
  logic [NUM_CH-1:0] r_mask_q, r_mask_d;
  logic              r_any_q, r_any_d;

  logic              clearing_c, pipe_empty_c, advance_c, idle_c;
  logic              cfg_ready_c, q_ready_c, cfg_fire_c, q_fire_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [WORD_W-1:0] ram_wdata_c;
  logic [NUM_CH-1:0] ram_we_c;
  logic [NUM_CH-1:0] mask_c;
  logic [WORD_W-1:0] ram_rdata [NUM_CH];

  // Handshakes: clear beats config beats query; config only on an empty pipeline.
  assign clearing_c   = (state_q == CLEAR);
  assign pipe_empty_c = !s1_valid_q && !r_valid_q;
  assign advance_c    = !r_valid_q || bus.r_ready;
  assign idle_c       = (state_q == IDLE) && rdy_en_q;
  assign cfg_ready_c  = idle_c && !bus.clr_req && pipe_empty_c;
  assign q_ready_c    = idle_c && !bus.clr_req && !bus.cfg_valid && advance_c;
  assign cfg_fire_c   = bus.cfg_valid && cfg_ready_c;
  assign q_fire_c     = bus.q_valid && q_ready_c;

  assign ram_addr_c  = clearing_c ? cnt_q :
                       cfg_fire_c ? bus.cfg_addr : bus.q_code[CODE_W-1:BIT_W];
  assign ram_wdata_c = clearing_c ? '0 : bus.cfg_data;

  always_comb begin
    ram_we_c = '0;
    mask_c   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ram_we_c[c] = clearing_c || (cfg_fire_c && (bus.cfg_ch == CH_W'(c)));
      // An enabled but unloaded channel reports blocked.
      mask_c[c]   = s1_en_q[c] && (!s1_tv_q[c] || ram_rdata[c][s1_bit_q]);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    prm_tbl_ram #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
    ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we_c[c]),
      .re_i    (q_fire_c),
      .addr_i  (ram_addr_c),
      .wdata_i (ram_wdata_c),
      .rdata_o (ram_rdata[c])
    );
  end

  // Next state: clear sweep, table-valid tracking and two-stage query pipeline.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tbl_valid_d = tbl_valid_q;
    s1_valid_d  = s1_valid_q;
    s1_bit_d    = s1_bit_q;
    s1_en_d     = s1_en_q;
    s1_tv_d     = s1_tv_q;
    r_valid_d   = r_valid_q;
    r_mask_d    = r_mask_q;
    r_any_d     = r_any_q;

    case (state_q)
      IDLE: begin
        if (rdy_en_q && bus.clr_req && pipe_empty_c) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d     = IDLE;
          tbl_valid_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_fire_c && bus.cfg_last) begin
      tbl_valid_d[bus.cfg_ch] = 1'b1;
    end

    if (advance_c) begin
      s1_valid_d = q_fire_c;
      if (q_fire_c) begin
        s1_bit_d = bus.q_code[BIT_W-1:0];
        s1_en_d  = bus.q_ch_en;
        s1_tv_d  = tbl_valid_q;
      end
      r_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        r_mask_d = mask_c;
        r_any_d  = |mask_c;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      tbl_valid_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_bit_q    <= '0;
      s1_en_q     <= '0;
      s1_tv_q     <= '0;
      r_valid_q   <= 1'b0;
      r_mask_q    <= '0;
      r_any_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= 1'b1;
      tbl_valid_q <= tbl_valid_d;
      s1_valid_q  <= s1_valid_d;
      s1_bit_q    <= s1_bit_d;
      s1_en_q     <= s1_en_d;
      s1_tv_q     <= s1_tv_d;
      r_valid_q   <= r_valid_d;
      r_mask_q    <= r_mask_d;
      r_any_q     <= r_any_d;
    end
  end

  // Readies depend on r_ready in the same cycle so the pipeline can stream at full rate.
  assign bus.cfg_ready = cfg_ready_c;
  assign bus.q_ready   = q_ready_c;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_mask    = r_mask_q;
  assign bus.r_any     = r_any_q;
  assign bus.tbl_valid = tbl_valid_q;
  assign bus.busy      = clearing_c || !pipe_empty_c;

endmodule

// File: tb/tb_prm_edge_mask_scanner.sv
// Directed self-checking bench for prm_edge_mask_scanner.
module tb_prm_edge_mask_scanner;

  localparam int unsigned CODE_W = 15;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WORD_W = 32;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  prm_edge_mask_scanner_if #(.CODE_W(CODE_W), .NUM_CH(NUM_CH), .WORD_W(WORD_W)) bus ();

  prm_edge_mask_scanner #(.CODE_W(CODE_W), .NUM_CH(NUM_CH), .WORD_W(WORD_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.cfg_last  = 1'b0;
    bus.clr_req   = 1'b0;
    bus.q_valid   = 1'b0;
    bus.q_code    = '0;
    bus.q_ch_en   = '0;
    bus.r_ready   = 1'b1;
  endtask

  // Entered and left at posedge+1.
  task automatic cfg_write(input logic [1:0] ch, input logic [9:0] addr,
                           input logic [31:0] data, input logic last);
    int n;
    n = 0;
    bus.cfg_ch = ch; bus.cfg_addr = addr; bus.cfg_data = data; bus.cfg_last = last;
    bus.cfg_valid = 1'b1;
    #1;
    while (!bus.cfg_ready && n < 20) begin
      @(posedge clk); #2; n++;
    end
    check("cfg_ready_seen", 32'(bus.cfg_ready), 32'h1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
  endtask

  // Returns at posedge+1 right after the accepting edge.
  task automatic send_q(input logic [14:0] code, input logic [3:0] en);
    int n;
    n = 0;
    bus.q_code = code; bus.q_ch_en = en; bus.q_valid = 1'b1;
    #1;
    while (!bus.q_ready && n < 20) begin
      @(posedge clk); #2; n++;
    end
    check("q_ready_seen", 32'(bus.q_ready), 32'h1);
    @(posedge clk); #1;
    bus.q_valid = 1'b0;
  endtask

  logic [14:0] s_code [8] = '{15'h068, 15'h069, 15'h068, 15'h069, 15'h069, 15'h068, 15'h060, 15'h068};
  logic [3:0]  s_en   [8] = '{4'b0001, 4'b0001, 4'b0011, 4'b0110, 4'b0011, 4'b1000, 4'b0101, 4'b1101};
  logic [3:0]  s_exp  [8] = '{4'b0001, 4'b0000, 4'b0011, 4'b0110, 4'b0010, 4'b1000, 4'b0100, 4'b1101};
  logic        pat    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int idx, oi, cyc, len, bad, n;
    logic acc, hold_v;
    logic [4:0] hold_val;

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'h0);
    check("rst_q_ready",   32'(bus.q_ready),   32'h0);
    check("rst_tbl_valid", 32'(bus.tbl_valid), 32'h0);
    check("rst_r_valid",   32'(bus.r_valid),   32'h0);
    check("rst_r_mask",    32'({bus.r_any, bus.r_mask}), 32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    tick();

    // Single load and query, latency and conservative unloaded channels.
    cfg_write(2'd0, 10'h003, 32'h0000_0100, 1'b1);
    check("t1_tbl_valid", 32'(bus.tbl_valid), 32'h1);
    send_q(15'h068, 4'b0001);
    check("t1_lat_not_yet", 32'(bus.r_valid), 32'h0);
    tick();
    check("t1_r_valid", 32'(bus.r_valid), 32'h1);
    check("t1_r_mask",  32'(bus.r_mask),  32'h1);
    check("t1_r_any",   32'(bus.r_any),   32'h1);
    tick();
    check("t1_r_drop", 32'(bus.r_valid), 32'h0);
    send_q(15'h069, 4'b1111);
    tick();
    check("t2_r_mask", 32'(bus.r_mask), 32'he);
    check("t2_r_any",  32'(bus.r_any),  32'h1);
    tick();

    // Back-to-back stream with r_ready pattern 1,0,0,1.
    idx = 0; oi = 0; cyc = 0; hold_v = 1'b0; hold_val = '0;
    while (oi < 8 && cyc < 60) begin
      bus.r_ready = pat[cyc % 4];
      bus.q_valid = (idx < 8);
      if (idx < 8) begin
        bus.q_code  = s_code[idx];
        bus.q_ch_en = s_en[idx];
      end
      #1;
      if (hold_v && bus.r_valid)
        check("stall_hold", 32'({bus.r_any, bus.r_mask}), 32'(hold_val));
      if (bus.r_valid && !bus.r_ready) begin
        check("stall_q_ready", 32'(bus.q_ready), 32'h0);
        hold_v   = 1'b1;
        hold_val = {bus.r_any, bus.r_mask};
      end else begin
        hold_v = 1'b0;
      end
      acc = bus.q_valid && bus.q_ready;
      if (bus.r_valid && bus.r_ready && oi < 8) begin
        check($sformatf("stream_%0d", oi), 32'({bus.r_any, bus.r_mask}),
              32'({|s_exp[oi], s_exp[oi]}));
        oi++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    check("stream_count", 32'(oi), 32'd8);
    bus.q_valid = 1'b0;
    bus.r_ready = 1'b1;
    #1;
    check("stream_no_dup", 32'(bus.r_valid), 32'h0);
    tick();

    // Clear request with two queries in flight.
    send_q(15'h068, 4'b0001);
    send_q(15'h069, 4'b1111);
    bus.clr_req = 1'b1;
    bus.q_code = 15'h068; bus.q_ch_en = 4'b0001; bus.q_valid = 1'b1;
    #1;
    check("clr_blocks_q", 32'(bus.q_ready), 32'h0);
    check("inflight_a", 32'({bus.r_valid, bus.r_mask}), 32'h11);
    tick();
    check("inflight_b", 32'({bus.r_valid, bus.r_mask}), 32'h1e);
    n = 0;
    while (!(bus.busy && !bus.r_valid) && n < 20) begin
      tick(); n++;
    end
    bus.clr_req = 1'b0;
    len = 0; bad = 0;
    while (bus.busy && len < 2000) begin
      if (bus.cfg_ready || bus.q_ready) bad++;
      len++;
      tick();
    end
    check("clr_len",       32'(len), 32'd1024);
    check("clr_ready_low", 32'(bad), 32'd0);
    check("clr_tbl_valid", 32'(bus.tbl_valid), 32'h0);
    #1;
    check("post_clr_q_ready", 32'(bus.q_ready), 32'h1);
    @(posedge clk); #1;
    bus.q_valid = 1'b0;
    tick();
    check("post_clr_mask", 32'({bus.r_valid, bus.r_mask}), 32'h11);
    tick();

    // All channels loaded at the top code.
    cfg_write(2'd1, 10'h3FF, 32'h0000_0000, 1'b1);
    check("ch1_only", 32'(bus.tbl_valid), 32'h2);
    cfg_write(2'd0, 10'h3FF, 32'h8000_0000, 1'b0);
    check("no_last_keep", 32'(bus.tbl_valid), 32'h2);
    cfg_write(2'd2, 10'h3FF, 32'h8000_0000, 1'b1);
    cfg_write(2'd3, 10'h3FF, 32'h0000_0000, 1'b1);
    cfg_write(2'd0, 10'h000, 32'h0000_0000, 1'b1);
    check("all_loaded", 32'(bus.tbl_valid), 32'hf);
    send_q(15'h7FFF, 4'b1111);
    tick();
    check("top_mask", 32'({bus.r_any, bus.r_mask}), 32'h15);
    tick();
    send_q(15'h7FFF, 4'b1010);
    tick();
    check("top_mask_en", 32'({bus.r_valid, bus.r_any, bus.r_mask}), 32'h20);
    tick();

    // Reset in the middle of a clear sweep.
    bus.clr_req = 1'b1;
    n = 0;
    while (!bus.busy && n < 20) begin
      tick(); n++;
    end
    bus.clr_req = 1'b0;
    repeat (500) tick();
    check("pre_rst_tv", 32'(bus.tbl_valid), 32'hf);
    #2 rst_n = 1'b0;
    #1;
    check("async_tbl_valid", 32'(bus.tbl_valid), 32'h0);
    check("async_busy",      32'(bus.busy),      32'h0);
    check("async_r_valid",   32'(bus.r_valid),   32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.cfg_ch = 2'd0; bus.cfg_addr = 10'h003; bus.cfg_data = 32'h0000_0100;
    bus.cfg_last = 1'b1; bus.cfg_valid = 1'b1;
    #1;
    check("rel_cfg_ready0", 32'(bus.cfg_ready), 32'h0);
    @(posedge clk); #1;
    check("rel_cfg_ready1", 32'(bus.cfg_ready), 32'h1);
    check("rel_tv_before",  32'(bus.tbl_valid), 32'h0);
    check("rel_busy",       32'(bus.busy),      32'h0);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
    check("rel_cfg_taken", 32'(bus.tbl_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
